// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: mode/state encodings and loader address width.
// Used by the mode loader and the controller.
package cpu_pkg;

    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIn    = 2'b01,
        StCheck = 2'b10,
        StRun   = 2'b11
    } cpu_state_t;

endpackage

// File: rtl/loader_debounce.sv
// Push-button conditioning: 2-flop synchronizer, optional debounce and rising-edge detect.
// Optional debounce filter is compiled in with LOADER_DEBOUNCE_EN.
module loader_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enter,
    output logic enter_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            level_q;
    logic            level_d;

    // Count consecutive samples that differ from the accepted level; any bounce restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= enter;
            sync2_q      <= sync1_q;
            level_prev_q <= level;
        end
    end

    assign enter_pulse = level & ~level_prev_q;

endmodule

// File: rtl/cpu_mode_loader.sv
// CPU mode FSM with switch-driven memory loader (IN writes, CHECK reads back).
// Enter debounce is optional via LOADER_DEBOUNCE_EN.
module cpu_mode_loader
    import cpu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_sel,
    input  logic              mode_req,
    input  logic              enter,
    input  logic [7:0]        sw_data,
    input  logic [7:0]        mem_rdata,
    output logic [1:0]        CPUstate,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [7:0]        ld_data,
    output logic              ld_we,
    output logic              ld_re,
    output logic [7:0]        check_data,
    output logic              check_valid,
    output logic              bus_own
);

    cpu_state_t        state_q, state_d;
    cpu_state_t        req_state;
    logic              req_prev_q;
    logic              req_rise;
    logic              enter_pulse;
    logic              busy;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        chk_data_q, chk_data_d;
    logic              chk_valid_q, chk_valid_d;

    loader_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .enter      (enter),
        .enter_pulse(enter_pulse)
    );

    assign req_rise  = mode_req & ~req_prev_q;
    assign req_state = cpu_state_t'(mode_sel);
    assign busy      = we_q | re_q | rd_pend_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        rd_pend_d   = re_q;
        chk_data_d  = chk_data_q;
        chk_valid_d = 1'b0;

        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        // A read already issued always completes, even across a mode change.
        if (rd_pend_q) begin
            chk_data_d  = mem_rdata;
            chk_valid_d = 1'b1;
            addr_d      = addr_q + ADDR_W'(1);
        end

        if (req_rise) begin
            state_d = req_state;
            if (req_state == StIn || req_state == StCheck) begin
                addr_d = '0;
            end
        end else if (enter_pulse && !busy) begin
            if (state_q == StIn) begin
                we_d   = 1'b1;
                data_d = sw_data;
            end else if (state_q == StCheck) begin
                re_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            req_prev_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            chk_data_q  <= '0;
            chk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_prev_q  <= mode_req;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            re_q        <= re_d;
            rd_pend_q   <= rd_pend_d;
            chk_data_q  <= chk_data_d;
            chk_valid_q <= chk_valid_d;
        end
    end

    assign bus_own     = (state_q == StIn) || (state_q == StCheck);
    assign CPUstate    = state_q;
    assign ld_addr     = addr_q;
    assign ld_data     = data_q;
    assign ld_we       = we_q & bus_own;
    assign ld_re       = re_q & bus_own;
    assign check_data  = chk_data_q;
    assign check_valid = chk_valid_q;

endmodule

// File: tb/tb_cpu_mode_loader.sv
// Scoreboard bench for cpu_mode_loader: expected accesses queued at stimulus, checked at the bus.
// Define LOADER_DEBOUNCE_EN to exercise the debounce build.
module tb_cpu_mode_loader;

`ifdef LOADER_DEBOUNCE_EN
    localparam int HOLD = 24;
`else
    localparam int HOLD = 4;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  mode_sel;
    logic        mode_req;
    logic        enter;
    logic [7:0]  sw_data;
    logic [7:0]  mem_rdata;
    logic [1:0]  CPUstate;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_we;
    logic        ld_re;
    logic [7:0]  check_data;
    logic        check_valid;
    logic        bus_own;

    cpu_mode_loader #(
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_sel   (mode_sel),
        .mode_req   (mode_req),
        .enter      (enter),
        .sw_data    (sw_data),
        .mem_rdata  (mem_rdata),
        .CPUstate   (CPUstate),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_we      (ld_we),
        .ld_re      (ld_re),
        .check_data (check_data),
        .check_valid(check_valid),
        .bus_own    (bus_own)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after ld_re.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        if (ld_re) mem_rdata <= mem[ld_addr];
    end

    int nvec = 0;
    int nerr = 0;
    logic [23:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic [7:0]  chk_q[$];
    logic [23:0] exp_wr;
    logic [15:0] exp_rd;
    logic [7:0]  exp_chk;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (ld_we) begin
            nvec++;
            if (wr_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_write addr=%h data=%h", ld_addr, ld_data);
            end else begin
                exp_wr = wr_q.pop_front();
                if ({ld_addr, ld_data} !== exp_wr) begin
                    nerr++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             ld_addr, ld_data, exp_wr[23:8], exp_wr[7:0]);
                end
            end
        end
        if (ld_re) begin
            nvec++;
            if (rd_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_read addr=%h", ld_addr);
            end else begin
                exp_rd = rd_q.pop_front();
                if (ld_addr !== exp_rd) begin
                    nerr++;
                    $display("FAIL read_addr got %h want %h", ld_addr, exp_rd);
                end
            end
        end
        if (check_valid) begin
            nvec++;
            if (prev_valid) begin
                nerr++;
                $display("FAIL check_valid_width got 2+ cycles want 1");
            end else if (chk_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_check data=%h", check_data);
            end else begin
                exp_chk = chk_q.pop_front();
                if (check_data !== exp_chk) begin
                    nerr++;
                    $display("FAIL check_data got %h want %h", check_data, exp_chk);
                end
            end
        end
        prev_valid = check_valid;
    end

    task automatic req_mode(input logic [1:0] m);
        @(negedge clk);
        mode_sel = m;
        mode_req = 1'b1;
        @(negedge clk);
        mode_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [7:0] d);
        @(negedge clk);
        sw_data = d;
        enter   = 1'b1;
        repeat (HOLD) @(negedge clk);
        enter = 1'b0;
        repeat (HOLD + 4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        mode_sel = 2'b00;
        mode_req = 1'b0;
        enter = 1'b0;
        sw_data = 8'h00;
        repeat (3) @(negedge clk);
        nvec++;
        if ({CPUstate, ld_addr, ld_data, ld_we, ld_re, check_data, check_valid, bus_own} !== 38'h0)
        begin
            nerr++;
            $display("FAIL reset_outputs got st=%b addr=%h d=%h we=%b re=%b cd=%h cv=%b own=%b want 0",
                     CPUstate, ld_addr, ld_data, ld_we, ld_re, check_data, check_valid, bus_own);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (CPUstate !== 2'b00) begin
            nerr++;
            $display("FAIL idle_after_reset got %b want 00", CPUstate);
        end
    endtask

    task automatic test_load;
        logic [7:0] vals [3];
        vals = '{8'hA5, 8'h3C, 8'hFF};
        req_mode(2'b01);
        nvec++;
        if (CPUstate !== 2'b01 || bus_own !== 1'b1 || ld_addr !== 16'h0000) begin
            nerr++;
            $display("FAIL enter_in got st=%b own=%b addr=%h want 01 1 0000",
                     CPUstate, bus_own, ld_addr);
        end
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back({16'(i), vals[i]});
            press(vals[i]);
        end
        nvec++;
        if (ld_addr !== 16'h0003 || wr_q.size() != 0) begin
            nerr++;
            $display("FAIL load_end got addr=%h pending=%0d want 0003 0", ld_addr, wr_q.size());
        end
    endtask

    task automatic test_check;
        req_mode(2'b10);
        nvec++;
        if (CPUstate !== 2'b10 || ld_addr !== 16'h0000 || bus_own !== 1'b1) begin
            nerr++;
            $display("FAIL enter_check got st=%b addr=%h own=%b want 10 0000 1",
                     CPUstate, ld_addr, bus_own);
        end
        rd_q.push_back(16'h0000);
        chk_q.push_back(8'hA5);
        press(8'h00);
        nvec++;
        if (ld_addr !== 16'h0001 || rd_q.size() != 0 || chk_q.size() != 0) begin
            nerr++;
            $display("FAIL check_end got addr=%h pend_rd=%0d pend_chk=%0d want 0001 0 0",
                     ld_addr, rd_q.size(), chk_q.size());
        end
        req_mode(2'b10);
        nvec++;
        if (ld_addr !== 16'h0000 || CPUstate !== 2'b10) begin
            nerr++;
            $display("FAIL reenter_check got addr=%h st=%b want 0000 10", ld_addr, CPUstate);
        end
    endtask

    task automatic test_wrap;
        req_mode(2'b01);
        @(negedge clk);
        force dut.addr_q = 16'hFFFF;
        @(negedge clk);
        release dut.addr_q;
        @(negedge clk);
        nvec++;
        if (ld_addr !== 16'hFFFF) begin
            nerr++;
            $display("FAIL wrap_preset got %h want ffff", ld_addr);
        end
        wr_q.push_back({16'hFFFF, 8'h5A});
        press(8'h5A);
        nvec++;
        if (ld_addr !== 16'h0000 || wr_q.size() != 0) begin
            nerr++;
            $display("FAIL wrap got addr=%h pending=%0d want 0000 0", ld_addr, wr_q.size());
        end
    endtask

    task automatic test_req_priority;
        bit found = 1'b0;
        @(negedge clk);
        sw_data = 8'h11;
        enter   = 1'b1;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (dut.enter_pulse === 1'b1) found = 1'b1;
        end
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL enter_pulse_timeout got none want pulse within 64 cycles");
        end
        mode_sel = 2'b11;
        mode_req = 1'b1;
        @(negedge clk);
        mode_req = 1'b0;
        repeat (HOLD) @(negedge clk);
        enter = 1'b0;
        repeat (HOLD + 4) @(negedge clk);
        nvec++;
        if (CPUstate !== 2'b11 || bus_own !== 1'b0 || ld_addr !== 16'h0000) begin
            nerr++;
            $display("FAIL req_priority got st=%b own=%b addr=%h want 11 0 0000",
                     CPUstate, bus_own, ld_addr);
        end
        press(8'h22);
        nvec++;
        if (ld_addr !== 16'h0000 || CPUstate !== 2'b11) begin
            nerr++;
            $display("FAIL run_ignores_enter got addr=%h st=%b want 0000 11", ld_addr, CPUstate);
        end
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        req_mode(2'b01);
        @(negedge clk);
        sw_data = 8'h99;
        enter   = 1'b1;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ld_we === 1'b1) found = 1'b1;
        end
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL reset_mid_timeout got no ld_we want one within 64 cycles");
        end
        rst = 1'b0;
        #1;
        nvec++;
        if (ld_we !== 1'b0 || ld_re !== 1'b0 || CPUstate !== 2'b00) begin
            nerr++;
            $display("FAIL reset_async got we=%b re=%b st=%b want 0 0 00", ld_we, ld_re, CPUstate);
        end
        enter = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (HOLD + 4) @(negedge clk);
        nvec++;
        if (CPUstate !== 2'b00 || ld_addr !== 16'h0000) begin
            nerr++;
            $display("FAIL reset_release got st=%b addr=%h want 00 0000", CPUstate, ld_addr);
        end
    endtask

`ifndef LOADER_DEBOUNCE_EN
    task automatic test_back_to_back;
        req_mode(2'b10);
        rd_q.push_back(16'h0000);
        chk_q.push_back(8'hA5);
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        repeat (12) @(negedge clk);
        nvec++;
        if (ld_addr !== 16'h0001 || rd_q.size() != 0 || chk_q.size() != 0) begin
            nerr++;
            $display("FAIL back_to_back got addr=%h pend_rd=%0d want 0001 0", ld_addr, rd_q.size());
        end
    endtask
`endif

`ifdef LOADER_DEBOUNCE_EN
    task automatic test_debounce;
        req_mode(2'b01);
        @(negedge clk);
        sw_data = 8'h77;
        enter   = 1'b1;
        repeat (5) @(negedge clk);
        enter = 1'b0;
        repeat (30) @(negedge clk);
        nvec++;
        if (ld_addr !== 16'h0000) begin
            nerr++;
            $display("FAIL glitch_filtered got addr=%h want 0000", ld_addr);
        end
        wr_q.push_back({16'h0000, 8'h77});
        enter = 1'b1;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        repeat (30) @(negedge clk);
        nvec++;
        if (ld_addr !== 16'h0001 || wr_q.size() != 0) begin
            nerr++;
            $display("FAIL debounced_press got addr=%h pending=%0d want 0001 0",
                     ld_addr, wr_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_check();
        test_wrap();
        test_req_priority();
        test_reset_mid();
`ifndef LOADER_DEBOUNCE_EN
        test_back_to_back();
`else
        test_debounce();
`endif
        nvec++;
        if (wr_q.size() + rd_q.size() + chk_q.size() != 0) begin
            nerr++;
            $display("FAIL leftover_expectations got wr=%0d rd=%0d chk=%0d want 0 0 0",
                     wr_q.size(), rd_q.size(), chk_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
